// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit CPU control path: opcodes, ALU selects,
// accumulator sources and sequencer states.
package cpu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_RSUB   = 4'h3;
  localparam logic [3:0] OP_NEGSUM = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_XOR    = 4'h7;
  localparam logic [3:0] OP_LDI    = 4'h8;
  localparam logic [3:0] OP_LDM    = 4'h9;
  localparam logic [3:0] OP_STA    = 4'hA;
  localparam logic [3:0] OP_JMP    = 4'hB;
  localparam logic [3:0] OP_JZ     = 4'hC;
  localparam logic [3:0] OP_RSV_D  = 4'hD;
  localparam logic [3:0] OP_RSV_E  = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS   = 3'b000,
    ALU_ADD    = 3'b001,
    ALU_SUB    = 3'b010,
    ALU_RSUB   = 3'b011,
    ALU_NEGSUM = 3'b100,
    ALU_AND    = 3'b101,
    ALU_OR     = 3'b110,
    ALU_XOR    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ACC_SEL_X   = 2'b00,
    ACC_SEL_IMM = 2'b01,
    ACC_SEL_MEM = 2'b10
  } acc_sel_e;

  // HALT needs its own encoding internally but shares debug code 11 with WRITEBACK.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  function automatic logic [1:0] state_dbg(input state_e s);
    return (s == ST_HALT) ? 2'b11 : s[1:0];
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: maps the latched opcode and sequencer
// state onto ALU, accumulator, data-memory and PC-load controls.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  state_e     state_i,
  input  logic       acc_zero_i,
  output logic [2:0] alu_op_o,
  output logic [1:0] acc_sel_o,
  output logic       acc_load_o,
  output logic       data_rd_o,
  output logic       data_we_o,
  output logic       pc_load_o,
  output logic       halt_o
);

  logic alu_op;

  assign alu_op = is_alu_op(opcode_i);

  always_comb begin
    alu_op_o   = ALU_PASS;
    acc_sel_o  = ACC_SEL_X;
    acc_load_o = 1'b0;
    data_rd_o  = 1'b0;
    data_we_o  = 1'b0;
    pc_load_o  = 1'b0;
    halt_o     = 1'b0;
    unique case (state_i)
      ST_EXECUTE: begin
        if (alu_op) alu_op_o = opcode_i[2:0];
        data_rd_o = alu_op || (opcode_i == OP_LDM);
        data_we_o = (opcode_i == OP_STA);
        pc_load_o = (opcode_i == OP_JMP) || ((opcode_i == OP_JZ) && acc_zero_i);
        halt_o    = (opcode_i == OP_HLT);
      end
      ST_WRITEBACK: begin
        if (alu_op) begin
          alu_op_o   = opcode_i[2:0];
          acc_sel_o  = ACC_SEL_X;
          acc_load_o = 1'b1;
        end else if (opcode_i == OP_LDI) begin
          acc_sel_o  = ACC_SEL_IMM;
          acc_load_o = 1'b1;
        end else if (opcode_i == OP_LDM) begin
          acc_sel_o  = ACC_SEL_MEM;
          acc_load_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK FSM with PC and IR;
// all datapath strobes are Moore outputs from the registered state and IR.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] INSTR_ADDR,
  input  logic [3+ADDR_W:0] INSTR_DATA,
  output logic [ADDR_W-1:0] DATA_ADDR,
  output logic              DATA_RD,
  output logic              DATA_WE,
  input  logic              ACC_ZERO,
  output logic [2:0]        ALU_OP,
  output logic [1:0]        ACC_SEL,
  output logic [DATA_W-1:0] IMM,
  output logic              ACC_LOAD,
  output logic              HALTED,
  output logic [1:0]        STATE
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3+ADDR_W:0] ir_q, ir_d;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              pc_load;
  logic              halt_go;

  assign opcode  = ir_q[3+ADDR_W -: 4];
  assign operand = ir_q[ADDR_W-1:0];

  cpu_instr_decode u_decode (
    .opcode_i   (opcode),
    .state_i    (state_q),
    .acc_zero_i (ACC_ZERO),
    .alu_op_o   (ALU_OP),
    .acc_sel_o  (ACC_SEL),
    .acc_load_o (ACC_LOAD),
    .data_rd_o  (DATA_RD),
    .data_we_o  (DATA_WE),
    .pc_load_o  (pc_load),
    .halt_o     (halt_go)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        // Program memory data arrives one cycle after the FETCH address.
        ir_d    = INSTR_DATA;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (pc_load) pc_d = operand;
        state_d = halt_go ? ST_HALT : ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  assign INSTR_ADDR = pc_q;
  assign DATA_ADDR  = operand;
  assign IMM        = ir_q[DATA_W-1:0];
  assign HALTED     = (state_q == ST_HALT);
  assign STATE      = state_dbg(state_q);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: table-driven single-instruction vectors,
// hand-written reset/halt sequences and random programs against a model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [3:0] data_addr;
  logic       data_rd, data_we, acc_zero;
  logic [2:0] alu_op;
  logic [1:0] acc_sel;
  logic [3:0] imm;
  logic       acc_load, halted;
  logic [1:0] state;

  always #5 clk = ~clk;

  cpu_control_unit #(.ADDR_W(4), .DATA_W(4)) dut (
    .CLK(clk), .RST(rst), .INSTR_ADDR(instr_addr), .INSTR_DATA(instr_data),
    .DATA_ADDR(data_addr), .DATA_RD(data_rd), .DATA_WE(data_we),
    .ACC_ZERO(acc_zero), .ALU_OP(alu_op), .ACC_SEL(acc_sel), .IMM(imm),
    .ACC_LOAD(acc_load), .HALTED(halted), .STATE(state)
  );

  logic [7:0] prog [16];
  always_ff @(posedge clk) instr_data <= prog[instr_addr];

  int n_vec = 0;
  int n_err = 0;
  int m_pc, m_ir;

  typedef struct packed {
    logic [1:0] st;
    logic       hlt;
    logic [3:0] iaddr;
    logic [3:0] daddr;
    logic       rd;
    logic       we;
    logic [2:0] alu;
    logic [1:0] sel;
    logic [3:0] imm;
    logic       load;
  } outs_t;

  function automatic outs_t get_outs();
    outs_t o;
    o = '{state, halted, instr_addr, data_addr, data_rd, data_we, alu_op, acc_sel, imm, acc_load};
    return o;
  endfunction

  // Expected outputs for one phase of an instruction (4 = halted).
  function automatic outs_t model(int phase, int pc, int ir);
    outs_t o;
    int op, opd;
    bit is_alu, reads, loads;
    op     = (ir >> 4) & 15;
    opd    = ir & 15;
    is_alu = (op >= 1) && (op <= 7);
    reads  = is_alu || (op == 9);
    loads  = is_alu || (op == 8) || (op == 9);
    o       = '0;
    o.st    = (phase == 4) ? 2'd3 : 2'(phase);
    o.hlt   = (phase == 4);
    o.iaddr = 4'(pc);
    o.daddr = 4'(opd);
    o.imm   = 4'(opd);
    if (phase == 2) begin
      o.rd  = reads;
      o.we  = (op == 10);
      o.alu = is_alu ? 3'(op) : 3'd0;
    end else if (phase == 3) begin
      o.load = loads;
      o.alu  = is_alu ? 3'(op) : 3'd0;
      o.sel  = (op == 8) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller fills prog while reset is held; returns at a negedge in FETCH.
  task automatic do_reset();
    rst = 1'b1;
    acc_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0;
    m_ir = 0;
  endtask

  task automatic run_instr(input bit az, output bit hlt);
    int nxt, op;
    hlt = 1'b0;
    acc_zero = 1'($urandom_range(0, 1));
    check("fetch", 32'(get_outs()), 32'(model(0, m_pc, m_ir)));
    @(negedge clk);
    check("decode", 32'(get_outs()), 32'(model(1, m_pc, m_ir)));
    nxt = prog[m_pc];
    @(negedge clk);
    m_ir = nxt;
    m_pc = (m_pc + 1) % 16;
    acc_zero = az;
    check("execute", 32'(get_outs()), 32'(model(2, m_pc, m_ir)));
    @(negedge clk);
    op = (m_ir >> 4) & 15;
    if (op == 11 || (op == 12 && az)) m_pc = m_ir & 15;
    acc_zero = 1'($urandom_range(0, 1));
    if (op == 15) begin
      for (int k = 0; k < 4; k++) begin
        check("halt", 32'(get_outs()), 32'(model(4, m_pc, m_ir)));
        @(negedge clk);
      end
      hlt = 1'b1;
    end else begin
      check("writeback", 32'(get_outs()), 32'(model(3, m_pc, m_ir)));
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         addr;
    logic [7:0] instr;
    bit         az;
    logic [8:0] ex;   // {rd, we, alu_op, data_addr} in EXECUTE
    logic [9:0] wb;   // {acc_load, acc_sel, alu_op, imm} in WRITEBACK
    logic [3:0] nxt;  // INSTR_ADDR at following FETCH
  } vec_t;

  vec_t vt[10];

  initial begin
    bit h;
    rst = 1'b1;
    acc_zero = 1'b0;

    vt[0] = '{0,  8'h85, 1'b0, {2'b00, 3'd0, 4'h5}, {1'b1, 2'd1, 3'd0, 4'h5}, 4'd1};
    vt[1] = '{0,  8'h13, 1'b0, {2'b10, 3'd1, 4'h3}, {1'b1, 2'd0, 3'd1, 4'h3}, 4'd1};
    vt[2] = '{2,  8'hA7, 1'b0, {2'b01, 3'd0, 4'h7}, {1'b0, 2'd0, 3'd0, 4'h7}, 4'd3};
    vt[3] = '{4,  8'hC9, 1'b1, {2'b00, 3'd0, 4'h9}, {1'b0, 2'd0, 3'd0, 4'h9}, 4'd9};
    vt[4] = '{4,  8'hC9, 1'b0, {2'b00, 3'd0, 4'h9}, {1'b0, 2'd0, 3'd0, 4'h9}, 4'd5};
    vt[5] = '{15, 8'h00, 1'b0, {2'b00, 3'd0, 4'h0}, {1'b0, 2'd0, 3'd0, 4'h0}, 4'd0};
    vt[6] = '{3,  8'hB3, 1'b0, {2'b00, 3'd0, 4'h3}, {1'b0, 2'd0, 3'd0, 4'h3}, 4'd3};
    vt[7] = '{7,  8'h96, 1'b0, {2'b10, 3'd0, 4'h6}, {1'b1, 2'd2, 3'd0, 4'h6}, 4'd8};
    vt[8] = '{1,  8'h7E, 1'b0, {2'b10, 3'd7, 4'hE}, {1'b1, 2'd0, 3'd7, 4'hE}, 4'd2};
    vt[9] = '{5,  8'hD2, 1'b1, {2'b00, 3'd0, 4'h2}, {1'b0, 2'd0, 3'd0, 4'h2}, 4'd6};

    for (int v = 0; v < 10; v++) begin
      rst = 1'b1;
      for (int a = 0; a < 16; a++) prog[a] = 8'h00;
      if (vt[v].addr != 0) prog[0] = 8'hB0 | 8'(vt[v].addr);
      prog[vt[v].addr] = vt[v].instr;
      do_reset();
      check("reset_state", 32'({state, halted, instr_addr, data_rd, data_we, acc_load, alu_op, acc_sel}),
            32'({2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0}));
      if (vt[v].addr != 0) run_instr(1'b0, h);
      acc_zero = ~vt[v].az;
      @(negedge clk);
      @(negedge clk);
      acc_zero = vt[v].az;
      check($sformatf("vec%0d_execute", v), 32'({data_rd, data_we, alu_op, data_addr}), 32'(vt[v].ex));
      @(negedge clk);
      acc_zero = ~vt[v].az;
      check($sformatf("vec%0d_writeback", v), 32'({acc_load, acc_sel, alu_op, imm}), 32'(vt[v].wb));
      @(negedge clk);
      check($sformatf("vec%0d_next_addr", v), 32'({state, instr_addr}), 32'({2'd0, vt[v].nxt}));
    end

    // HLT at address 6, then reset asserted mid-HALT.
    rst = 1'b1;
    for (int a = 0; a < 16; a++) prog[a] = 8'h00;
    prog[6] = 8'hF0;
    do_reset();
    for (int i = 0; i < 7; i++) run_instr(1'($urandom_range(0, 1)), h);
    check("halt_entered", 32'(h), 32'(1));
    for (int i = 0; i < 6; i++) begin
      acc_zero = 1'($urandom_range(0, 1));
      check("halt_frozen", 32'({state, halted, instr_addr, data_rd, data_we, acc_load, alu_op, acc_sel}),
            32'({2'd3, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0}));
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 check("halt_async_reset", 32'({state, halted, instr_addr}), 32'({2'd0, 1'b0, 4'd0}));
    @(negedge clk);
    rst = 1'b0;
    check("after_halt_reset", 32'({state, halted, instr_addr}), 32'({2'd0, 1'b0, 4'd0}));
    @(negedge clk);
    check("after_halt_decode", 32'({state, instr_addr}), 32'({2'd1, 4'd0}));

    // Reset in the middle of a STA must drop the write strobe immediately.
    rst = 1'b1;
    for (int a = 0; a < 16; a++) prog[a] = 8'h00;
    prog[0] = 8'hA7;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    check("sta_we_before_abort", 32'({state, data_we}), 32'({2'd2, 1'b1}));
    #2 rst = 1'b1;
    #1 check("sta_abort", 32'({state, data_we, data_addr, instr_addr}), 32'({2'd0, 1'b0, 4'd0, 4'd0}));
    @(negedge clk);
    rst = 1'b0;

    // Random programs against the model; HLT kept rare so programs run a while.
    rst = 1'b1;
    for (int a = 0; a < 16; a++) prog[a] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 250; n++) begin
      run_instr(1'($urandom_range(0, 1)), h);
      if (h) begin
        rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
          prog[a] = 8'($urandom);
          if (prog[a][7:4] == 4'hF && $urandom_range(0, 7) != 0) prog[a][7:4] = 4'h0;
        end
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
